main_mem_arbiter: RTL and testbench

//  Shares main-memory port A between two requesters: CPU vector load/store (req 0) and the

---
 rtl/main_mem_pkg.sv | 17 +
 rtl/main_mem_arbiter_rd_tag_pipe.sv | 40 ++++
 rtl/main_mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_main_mem_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types and constants for the main-memory port A arbiter.
// The 72-bit word is six 12-bit lanes; packing is handled upstream.
package main_mem_pkg;
    localparam int MAIN_BASE = 76;
    localparam int LANES     = 6;
    localparam int LANE_W    = 12;
    localparam int PACK_W    = LANES * LANE_W;
    localparam int ADDR_W    = 20;
    localparam int MEM_AW    = 19;

    typedef enum logic {REQ_CPU = 1'b0, REQ_LOADER = 1'b1} req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t owner;
    } rd_tag_t;
endpackage

// File: rtl/main_mem_arbiter_rd_tag_pipe.sv
// Shift pipe carrying read-return tags alongside the memory read latency.
// Reset flushes every stage so no pre-reset read ever returns.
module rd_tag_pipe
    import main_mem_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out,
    output logic    any_vld
);

    rd_tag_t stage_p [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_p[i].valid <= 1'b0;
                stage_p[i].owner <= REQ_CPU;
            end
        end else begin
            stage_p[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_p[i] <= stage_p[i-1];
            end
        end
    end

    assign tag_out = stage_p[DEPTH-1];

    always_comb begin
        any_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld = any_vld | stage_p[i].valid;
        end
    end

endmodule

// File: rtl/main_mem_arbiter.sv
// Round-robin arbiter sharing main-memory port A between CPU vector access and the
// host image loader, with lock sequences, base-offset translation and read routing.
module main_mem_arbiter
    import main_mem_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int LOCK_MAX = 8,
    parameter int BASE     = MAIN_BASE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  req,
    input  logic [1:0]                  we,
    input  logic [1:0]                  lock,
    input  logic [1:0][ADDR_W-1:0]      addr,
    input  logic [1:0][PACK_W-1:0]      wdata,
    output logic [1:0]                  gnt,
    output logic [1:0]                  err,
    output logic [1:0]                  rvalid,
    output logic [PACK_W-1:0]           rdata,
    output logic [MEM_AW-1:0]           mem_addr,
    output logic [PACK_W-1:0]           mem_data,
    output logic                        mem_wren,
    input  logic [PACK_W-1:0]           mem_q,
    output logic                        busy
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    function automatic logic [1:0] onehot(req_id_t id);
        return (id == REQ_LOADER) ? 2'b10 : 2'b01;
    endfunction

    req_id_t            rr_ptr;
    req_id_t            lock_owner;
    logic               lock_held;
    logic [CNT_W-1:0]   lock_cnt;

    logic [1:0]         in_range;
    logic [1:0]         eligible;
    logic [1:0]         cand;
    logic [1:0]         err_d;
    logic               any_gnt;
    req_id_t            winner;
    logic [MEM_AW-1:0]  off;
    logic [CNT_W-1:0]   cnt_nxt;
    rd_tag_t            tag_in;
    rd_tag_t            tag_out;
    logic               pipe_vld;

    // Arbitration: a held lock narrows eligibility to its owner; out-of-range
    // requests are never candidates and are reported once through err.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            in_range[i] = (addr[i] >= ADDR_W'(BASE));
        end
        eligible = 2'b11;
        if (lock_held) begin
            eligible = onehot(lock_owner);
        end
        cand    = req & in_range & eligible;
        err_d   = req & ~in_range & eligible & ~err;
        any_gnt = |cand;
        if (cand == 2'b11) begin
            winner = rr_ptr;
        end else if (cand[1]) begin
            winner = REQ_LOADER;
        end else begin
            winner = REQ_CPU;
        end
        gnt          = any_gnt ? onehot(winner) : 2'b00;
        off          = MEM_AW'(addr[winner] - ADDR_W'(BASE));
        cnt_nxt      = lock_held ? (lock_cnt + CNT_W'(1)) : CNT_W'(1);
        tag_in.valid = any_gnt & ~we[winner];
        tag_in.owner = winner;
    end

    // Round-robin pointer and lock tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= REQ_CPU;
            lock_owner <= REQ_CPU;
            lock_held  <= 1'b0;
            lock_cnt   <= '0;
            err        <= 2'b00;
        end else begin
            err <= err_d;
            if (any_gnt) begin
                rr_ptr <= req_id_t'(~winner);
                if (lock[winner] && (cnt_nxt < CNT_W'(LOCK_MAX))) begin
                    lock_held  <= 1'b1;
                    lock_owner <= winner;
                    lock_cnt   <= cnt_nxt;
                end else begin
                    lock_held <= 1'b0;
                    lock_cnt  <= '0;
                end
            end else if (lock_held && !lock[lock_owner]) begin
                lock_held <= 1'b0;
                lock_cnt  <= '0;
            end
        end
    end

    // Command stage: one registered access per grant
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
        end else begin
            mem_wren <= any_gnt & we[winner];
            if (any_gnt) begin
                mem_addr <= off;
                mem_data <= wdata[winner];
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out),
        .any_vld (pipe_vld)
    );

    // Return stage: capture q_a as the matching tag leaves the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 2'b00;
            rdata  <= '0;
        end else begin
            rvalid <= tag_out.valid ? onehot(tag_out.owner) : 2'b00;
            if (tag_out.valid) begin
                rdata <= mem_q;
            end
        end
    end

    assign busy = pipe_vld | lock_held;

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Directed bench for main_mem_arbiter with a behavioural main memory and a
// read-return scoreboard checked against grant order, data and return cycle.
module tb_main_mem_arbiter;

    localparam int RD_LAT = 2;
    localparam int BASE   = 76;

    typedef struct {
        logic [1:0]  vec;
        logic [71:0] data;
        int          due;
    } exp_rd_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req, we, lock;
    logic [1:0][19:0]  addr;
    logic [1:0][71:0]  wdata;
    logic [1:0]        gnt, err, rvalid;
    logic [71:0]       rdata;
    logic [18:0]       mem_addr;
    logic [71:0]       mem_data;
    logic              mem_wren;
    logic [71:0]       mem_q;
    logic              busy;

    logic [71:0]       mem [512];
    logic [71:0]       gm  [512];
    logic [71:0]       s1;
    exp_rd_t           sb [$];
    exp_rd_t           mon_e;
    int                cyc = 0;
    int                n_cmp = 0;
    int                n_bad = 0;

    main_mem_arbiter #(.RD_LAT(RD_LAT), .LOCK_MAX(8), .BASE(BASE)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .lock     (lock),
        .addr     (addr),
        .wdata    (wdata),
        .gnt      (gnt),
        .err      (err),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wren (mem_wren),
        .mem_q    (mem_q),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [71:0] init_val(int i);
        return {36'hC0FFEE000 + 36'(i), 36'(i * 7)};
    endfunction

    // Main memory: address registered by the DUT, data out RD_LAT cycles later
    always @(posedge clk) begin
        if (mem_wren) mem[mem_addr[8:0]] <= mem_data;
        s1    <= mem[mem_addr[8:0]];
        mem_q <= s1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid !== 2'b00) begin
            if (sb.size() == 0) begin
                chk("rvalid_unexpected", 72'(rvalid), 72'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("rvalid_owner", 72'(rvalid), 72'(mon_e.vec));
                chk("rdata", rdata, mon_e.data);
                chk("rvalid_cycle", 72'(cyc), 72'(mon_e.due));
            end
        end
    end

    task automatic set_req(input int k, input bit r, input bit w, input bit l,
                           input logic [19:0] a, input logic [71:0] d);
        req[k] = r; we[k] = w; lock[k] = l; addr[k] = a; wdata[k] = d;
    endtask

    task automatic idle_all();
        req = 2'b00; we = 2'b00; lock = 2'b00;
    endtask

    task automatic cycle_gnt(input string tag, input logic [1:0] exp_g, input bit push);
        logic [8:0] idx;
        #1;
        chk(tag, 72'(gnt), 72'(exp_g));
        for (int k = 0; k < 2; k++) begin
            if (exp_g[k]) begin
                idx = 9'(addr[k] - 20'(BASE));
                if (we[k]) gm[idx] = wdata[k];
                else if (push) sb.push_back('{vec: (k == 1) ? 2'b10 : 2'b01,
                                              data: gm[idx], due: cyc + RD_LAT + 2});
            end
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain", 72'(sb.size()), 72'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem[i] = init_val(i);
            gm[i]  = init_val(i);
        end
        rst = 1'b1; req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("idle_ctl", 72'({gnt, err, rvalid, mem_wren, busy}), 72'd0);
        end
        chk("idle_mem_addr", 72'(mem_addr), 72'd0);
        chk("idle_mem_data", mem_data, 72'd0);
        chk("idle_rdata", rdata, 72'd0);

        // CPU write and command translation
        @(negedge clk); set_req(0, 1, 1, 0, 20'd100, 72'h123); cycle_gnt("wr_gnt", 2'b01, 1);
        @(negedge clk); idle_all(); #1;
        chk("wr_mem_addr", 72'(mem_addr), 72'd24);
        chk("wr_wren", 72'(mem_wren), 72'd1);
        chk("wr_mem_data", mem_data, 72'h123);
        @(negedge clk); #1; chk("wren_clear", 72'(mem_wren), 72'd0);

        @(negedge clk); set_req(1, 1, 1, 0, 20'd200, 72'hABC); cycle_gnt("ldw_gnt", 2'b10, 1);
        @(negedge clk); idle_all(); #1; chk("ldw_mem_addr", 72'(mem_addr), 72'd124);

        // Both requesting reads every cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_req(0, 1, 0, 0, 20'd80, 72'd0);
            set_req(1, 1, 0, 0, 20'd90, 72'd0);
            cycle_gnt("rr_gnt", (i % 2 == 1) ? 2'b10 : 2'b01, 1);
        end
        @(negedge clk); idle_all(); #1; chk("rd_busy", 72'(busy), 72'd1);
        wait_drain();

        // Write after read to the same address
        @(negedge clk); set_req(0, 1, 0, 0, 20'd100, 72'd0);    cycle_gnt("war_rd", 2'b01, 1);
        @(negedge clk); set_req(0, 1, 1, 0, 20'd100, 72'h456);  cycle_gnt("war_wr", 2'b01, 1);
        @(negedge clk); set_req(0, 1, 0, 0, 20'd100, 72'd0);    cycle_gnt("war_rd2", 2'b01, 1);
        @(negedge clk); idle_all();
        wait_drain();

        // Locked loader writes hold off a pending CPU for LOCK_MAX grants
        @(negedge clk); set_req(1, 1, 1, 1, 20'd300, 72'h1000); cycle_gnt("lock_gnt0", 2'b10, 1);
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            set_req(1, 1, 1, 1, 20'(300 + i), 72'(4096 + i));
            set_req(0, 1, 1, 0, 20'd110, 72'h777);
            cycle_gnt("lock_gnt", 2'b10, 1);
            chk("lock_busy", 72'(busy), 72'd1);
        end
        @(negedge clk); set_req(1, 1, 1, 1, 20'd308, 72'h1008);
        cycle_gnt("lock_max_cpu", 2'b01, 1);
        chk("lock_rel_busy", 72'(busy), 72'd0);

        // Lock held while the owner is idle, then released by dropping lock
        @(negedge clk); idle_all(); set_req(1, 1, 0, 1, 20'd90, 72'd0); cycle_gnt("lk_idle_gnt", 2'b10, 1);
        @(negedge clk); set_req(1, 0, 0, 1, 20'd90, 72'd0); set_req(0, 1, 0, 0, 20'd80, 72'd0);
        cycle_gnt("lk_block", 2'b00, 1);
        @(negedge clk); set_req(1, 0, 0, 0, 20'd90, 72'd0); cycle_gnt("lk_rel_cyc", 2'b00, 1);
        @(negedge clk); cycle_gnt("lk_after", 2'b01, 1);
        @(negedge clk); idle_all(); set_req(1, 1, 0, 0, 20'd90, 72'd0); cycle_gnt("ld_rd", 2'b10, 1);
        @(negedge clk); idle_all();
        wait_drain();

        // Out-of-range request
        @(negedge clk); set_req(0, 1, 0, 0, 20'd40, 72'd0); cycle_gnt("err_nogt", 2'b00, 1);
        @(negedge clk); cycle_gnt("err_hold", 2'b00, 1);
        chk("err_pulse", 72'(err), 72'b01);
        chk("err_wren", 72'(mem_wren), 72'd0);
        chk("err_maddr", 72'(mem_addr), 72'd14);
        @(negedge clk); idle_all(); #1; chk("err_once", 72'(err), 72'd0);
        @(negedge clk); set_req(0, 1, 0, 0, 20'd80, 72'd0); set_req(1, 1, 0, 0, 20'd90, 72'd0);
        cycle_gnt("err_rr", 2'b01, 1);
        @(negedge clk); idle_all();
        wait_drain();

        // Reset while a read is in flight
        @(negedge clk); set_req(0, 1, 0, 0, 20'd90, 72'd0); cycle_gnt("rst_rd", 2'b01, 0);
        @(negedge clk); idle_all(); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_rdata", rdata, 72'd0);
        chk("rst_maddr", 72'(mem_addr), 72'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            chk("rst_no_rvalid", 72'(rvalid), 72'd0);
        end
        chk("sb_empty", 72'(sb.size()), 72'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
